// File: rtl/buf_xchg_pkg.sv
// Shared types for the inter-core buffer exchange: FSM states, slot layout, address width.
package buf_xchg_pkg;
  localparam int SLOT_ADDR_W = 3;
  localparam int MAX_CORES   = 8;
  localparam int SLOT_DATA_W = 32;

  typedef enum logic [1:0] {
    GATHER  = 2'd0,
    RELEASE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [SLOT_DATA_W-1:0] val_1;
    logic [SLOT_DATA_W-1:0] val_2;
  } slot_t;
endpackage

// File: rtl/buf_exchange_ctrl_slot_table.sv
// Per-core slot registers with per-slot write enables and 2*NUM_CORES registered lookups.
// Lookups sample the pre-write contents, so a same-cycle capture is seen one cycle later.
module buf_slot_table
  import buf_xchg_pkg::*;
#(
  parameter int NUM_CORES = 8,
  parameter int DATA_W    = 32
) (
  input  logic                                    Clk,
  input  logic                                    Reset,
  input  logic [NUM_CORES-1:0]                    wr_en,
  input  logic [NUM_CORES-1:0][DATA_W-1:0]        wr_val_1,
  input  logic [NUM_CORES-1:0][DATA_W-1:0]        wr_val_2,
  input  logic [NUM_CORES-1:0][SLOT_ADDR_W-1:0]   rd_addr_1,
  input  logic [NUM_CORES-1:0][SLOT_ADDR_W-1:0]   rd_addr_2,
  output logic [NUM_CORES-1:0][DATA_W-1:0]        rd_data_1,
  output logic [NUM_CORES-1:0][DATA_W-1:0]        rd_data_2
);
  slot_t [NUM_CORES-1:0]            slot_q, slot_d;
  logic  [NUM_CORES-1:0][DATA_W-1:0] rd_1_q, rd_1_d, rd_2_q, rd_2_d;

  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (wr_en[i]) begin
        slot_d[i].val_1 = SLOT_DATA_W'(wr_val_1[i]);
        slot_d[i].val_2 = SLOT_DATA_W'(wr_val_2[i]);
      end
    end
  end

  // Compare-based mux: addresses past the last slot match nothing and read 0.
  always_comb begin
    rd_1_d = '0;
    rd_2_d = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (rd_addr_1[i] == SLOT_ADDR_W'(j)) rd_1_d[i] = DATA_W'(slot_q[j].val_1);
        if (rd_addr_2[i] == SLOT_ADDR_W'(j)) rd_2_d[i] = DATA_W'(slot_q[j].val_2);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      slot_q <= '0;
      rd_1_q <= '0;
      rd_2_q <= '0;
    end else begin
      slot_q <= slot_d;
      rd_1_q <= rd_1_d;
      rd_2_q <= rd_2_d;
    end
  end

  assign rd_data_1 = rd_1_q;
  assign rd_data_2 = rd_2_q;
endmodule

// File: rtl/buf_exchange_ctrl.sv
// Barrier/broadcast controller: gathers per-core buffer values, releases all_buf_flags once every
// active core has arrived. Optional gather timeout enabled by defining BUF_TIMEOUT_EN.
module buf_exchange_ctrl
  import buf_xchg_pkg::*;
#(
  parameter int NUM_CORES   = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [NUM_CORES-1:0]               core_en,
  input  logic [NUM_CORES-1:0]               buf_flag,
  input  logic [NUM_CORES*DATA_W-1:0]        buf_val_1,
  input  logic [NUM_CORES*DATA_W-1:0]        buf_val_2,
  input  logic [NUM_CORES*SLOT_ADDR_W-1:0]   buf_val_1_addr,
  input  logic [NUM_CORES*SLOT_ADDR_W-1:0]   buf_val_2_addr,
  output logic [NUM_CORES*DATA_W-1:0]        buf_val_1_select,
  output logic [NUM_CORES*DATA_W-1:0]        buf_val_2_select,
  output logic                               all_buf_flags,
  output logic [15:0]                        round_cnt,
  output logic [NUM_CORES-1:0]               timeout_mask
);
  state_e                           state_q, state_d;
  logic [NUM_CORES-1:0]             active_q, active_d, arrived_q, arrived_d;
  logic [NUM_CORES-1:0]             cap, fill, wr_en;
  logic                             flag_q, flag_d;
  logic [15:0]                      round_q, round_d;
  logic                             done, drained, tmo_hit;
  logic [NUM_CORES-1:0][DATA_W-1:0] val_1, val_2, wr_val_1, wr_val_2;

  assign val_1   = buf_val_1;
  assign val_2   = buf_val_2;
  assign cap     = (state_q == GATHER) ? (buf_flag & active_q & ~arrived_q) : '0;
  assign done    = ((arrived_q | cap) == active_q);
  assign drained = ((buf_flag & active_q) == '0);

`ifdef BUF_TIMEOUT_EN
  logic                 tmo_run_q, tmo_run_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [NUM_CORES-1:0] tmask_q, tmask_d;

  assign tmo_hit = (state_q == GATHER) && tmo_run_q && (tmo_cnt_q == 16'(TIMEOUT_CYC));
  // Cores still missing when the timer expires get their slots zeroed.
  assign fill    = (tmo_hit && !done) ? (active_q & ~(arrived_q | cap)) : '0;

  always_comb begin
    tmo_run_d = 1'b0;
    tmo_cnt_d = '0;
    tmask_d   = (tmo_hit && !done) ? fill : tmask_q;
    if (state_q == GATHER && state_d == GATHER) begin
      if (tmo_run_q) begin
        tmo_run_d = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 16'd1;
      end else if (|cap) begin
        tmo_run_d = 1'b1;
        tmo_cnt_d = 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      tmo_run_q <= 1'b0;
      tmo_cnt_q <= '0;
      tmask_q   <= '0;
    end else begin
      tmo_run_q <= tmo_run_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmask_q   <= tmask_d;
    end
  end

  assign timeout_mask = tmask_q;
`else
  logic unused_tmo;
  assign unused_tmo   = |TIMEOUT_CYC;
  assign tmo_hit      = 1'b0;
  assign fill         = '0;
  assign timeout_mask = '0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= GATHER;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GATHER:  if (done || tmo_hit) state_d = RELEASE;
      RELEASE: state_d = DRAIN;
      DRAIN:   if (drained) state_d = GATHER;
      default: state_d = GATHER;
    endcase
  end

  always_comb begin
    arrived_d = arrived_q | cap;
    active_d  = active_q;
    flag_d    = flag_q;
    round_d   = round_q;
    wr_en     = cap | fill;
    for (int i = 0; i < NUM_CORES; i++) begin
      wr_val_1[i] = fill[i] ? '0 : val_1[i];
      wr_val_2[i] = fill[i] ? '0 : val_2[i];
    end
    if (state_q == GATHER && state_d == RELEASE) flag_d = 1'b1;
    // Round closes here; the participation mask for the next round is sampled now.
    if (state_q == DRAIN && drained) begin
      flag_d    = 1'b0;
      arrived_d = '0;
      round_d   = round_q + 16'd1;
      active_d  = core_en;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      active_q  <= core_en;
      arrived_q <= '0;
      flag_q    <= 1'b0;
      round_q   <= '0;
    end else begin
      active_q  <= active_d;
      arrived_q <= arrived_d;
      flag_q    <= flag_d;
      round_q   <= round_d;
    end
  end

  assign all_buf_flags = flag_q;
  assign round_cnt     = round_q;

  buf_slot_table #(
    .NUM_CORES (NUM_CORES),
    .DATA_W    (DATA_W)
  ) u_slots (
    .Clk       (Clk),
    .Reset     (Reset),
    .wr_en     (wr_en),
    .wr_val_1  (wr_val_1),
    .wr_val_2  (wr_val_2),
    .rd_addr_1 (buf_val_1_addr),
    .rd_addr_2 (buf_val_2_addr),
    .rd_data_1 (buf_val_1_select),
    .rd_data_2 (buf_val_2_select)
  );
endmodule

// File: tb/tb_buf_exchange_ctrl.sv
// Directed bench for buf_exchange_ctrl (4 cores); timeout round runs when BUF_TIMEOUT_EN is defined.
module tb_buf_exchange_ctrl;
  localparam int NC = 4;
  localparam int DW = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [NC-1:0]     core_en, buf_flag;
  logic [NC*DW-1:0]  buf_val_1, buf_val_2, sel_1, sel_2;
  logic [NC*3-1:0]   addr_1, addr_2;
  logic              all_buf_flags;
  logic [15:0]       round_cnt;
  logic [NC-1:0]     timeout_mask;
  int                n_tests = 0;
  int                n_fail = 0;

  buf_exchange_ctrl #(.NUM_CORES(NC), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .core_en          (core_en),
    .buf_flag         (buf_flag),
    .buf_val_1        (buf_val_1),
    .buf_val_2        (buf_val_2),
    .buf_val_1_addr   (addr_1),
    .buf_val_2_addr   (addr_2),
    .buf_val_1_select (sel_1),
    .buf_val_2_select (sel_2),
    .all_buf_flags    (all_buf_flags),
    .round_cnt        (round_cnt),
    .timeout_mask     (timeout_mask)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_v(input int i, input logic [31:0] v1, input logic [31:0] v2);
    buf_val_1[i*DW +: DW] = v1;
    buf_val_2[i*DW +: DW] = v2;
  endtask

  task automatic set_a(input int i, input logic [2:0] a1, input logic [2:0] a2);
    addr_1[i*3 +: 3] = a1;
    addr_2[i*3 +: 3] = a2;
  endtask

  function automatic logic [31:0] s1(input int i);
    return sel_1[i*DW +: DW];
  endfunction

  function automatic logic [31:0] s2(input int i);
    return sel_2[i*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    core_en = 4'hF; buf_flag = '0; buf_val_1 = '0; buf_val_2 = '0; addr_1 = '0; addr_2 = '0;
    tick(); tick();
    Reset = 1'b1;
    chk("rst_rel", 32'(all_buf_flags), 0);
    chk("rst_rnd", 32'(round_cnt), 0);
    chk("rst_sel", s1(0), 0);
    chk("rst_tmask", 32'(timeout_mask), 0);

    // T1: staggered arrivals; flag value applied before edge c is captured at edge c
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin set_v(0, 1, 32'h100); buf_flag[0] = 1'b1; end
      if (c == 5) begin set_v(1, 2, 32'h101); buf_flag[1] = 1'b1; end
      if (c == 7) begin set_v(2, 3, 32'h102); buf_flag[2] = 1'b1; end
      if (c == 9) begin set_v(3, 4, 32'h103); buf_flag[3] = 1'b1; end
      tick();
      chk("t1_rel", 32'(all_buf_flags), 32'(c >= 9));
    end
    chk("t1_rnd_hold", 32'(round_cnt), 0);
    buf_flag = '0;
    tick();
    chk("t1_drop", 32'(all_buf_flags), 0);
    chk("t1_rnd", 32'(round_cnt), 1);
    for (int i = 0; i < NC; i++) set_a(i, 3'(i), 3'(i));
    tick();
    for (int i = 0; i < NC; i++) begin
      chk("t1_slot_v1", s1(i), 32'(i + 1));
      chk("t1_slot_v2", s2(i), 32'h100 + 32'(i));
    end

    // T2: simultaneous arrivals, single release
    for (int i = 0; i < NC; i++) set_v(i, 32'h20 + 32'(i), 32'h30 + 32'(i));
    buf_flag = 4'hF;
    tick();
    chk("t2_rel", 32'(all_buf_flags), 1);
    chk("t2_rnd_rel", 32'(round_cnt), 1);
    core_en = 4'b0101;
    tick();
    chk("t2_drain", 32'(all_buf_flags), 1);
    buf_flag = '0;
    tick();
    chk("t2_drop", 32'(all_buf_flags), 0);
    chk("t2_rnd", 32'(round_cnt), 2);
    tick();
    for (int i = 0; i < NC; i++) begin
      chk("t2_slot_v1", s1(i), 32'h20 + 32'(i));
      chk("t2_slot_v2", s2(i), 32'h30 + 32'(i));
    end

    // T3: mask 0101, inactive cores ignored in GATHER and DRAIN
    set_v(1, 32'hBAD1, 32'hBAD2); set_v(3, 32'hBAD3, 32'hBAD4);
    buf_flag = 4'b1010;
    tick(); tick(); tick();
    chk("t3_ign", 32'(all_buf_flags), 0);
    set_v(0, 32'h40, 32'h50); set_v(2, 32'h42, 32'h52);
    buf_flag = 4'hF;
    tick();
    chk("t3_rel", 32'(all_buf_flags), 1);
    tick();
    buf_flag = 4'b1010;
    core_en = 4'hF;
    tick();
    chk("t3_drop", 32'(all_buf_flags), 0);
    chk("t3_rnd", 32'(round_cnt), 3);
    buf_flag = '0;
    tick();
    chk("t3_s0", s1(0), 32'h40);
    chk("t3_s1", s1(1), 32'h21);
    chk("t3_s1v2", s2(1), 32'h31);
    chk("t3_s2", s1(2), 32'h42);
    chk("t3_s3", s1(3), 32'h23);
    chk("t3_tmask", 32'(timeout_mask), 0);

    // T4: read-before-write and out-of-range address
    set_v(1, 32'hAAAA, 32'hBBBB);
    buf_flag = 4'b0010;
    set_a(2, 3'd1, 3'd1);
    set_a(3, 3'd5, 3'd5);
    tick();
    chk("t4_old_v1", s1(2), 32'h21);
    chk("t4_old_v2", s2(2), 32'h31);
    chk("t4_oor", s1(3), 0);
    tick();
    chk("t4_new_v1", s1(2), 32'hAAAA);
    chk("t4_new_v2", s2(2), 32'hBBBB);
    chk("t4_oor2", s2(3), 0);

    // T5: reset during DRAIN
    set_v(0, 32'h60, 32'h61); set_v(2, 32'h62, 32'h63); set_v(3, 32'h64, 32'h65);
    buf_flag = 4'hF;
    tick();
    chk("t5_rel", 32'(all_buf_flags), 1);
    tick();
    chk("t5_drain", 32'(all_buf_flags), 1);
    chk("t5_rnd_pre", 32'(round_cnt), 3);
    Reset = 1'b0;
    buf_flag = '0;
    tick();
    Reset = 1'b1;
    chk("t5_rel_rst", 32'(all_buf_flags), 0);
    chk("t5_rnd_rst", 32'(round_cnt), 0);
    for (int i = 0; i < NC; i++) set_a(i, 3'(i), 3'(i));
    tick();
    for (int i = 0; i < NC; i++) begin
      chk("t5_slot_v1", s1(i), 0);
      chk("t5_slot_v2", s2(i), 0);
    end

    // Fresh round after reset counts from zero
    for (int i = 0; i < NC; i++) set_v(i, 32'h70 + 32'(i), 32'h80 + 32'(i));
    buf_flag = 4'hF;
    tick(); tick();
    buf_flag = '0;
    tick();
    chk("t5_rnd_after", 32'(round_cnt), 1);
    chk("t5_rel_after", 32'(all_buf_flags), 0);
    tick();
    chk("t5_s3", s1(3), 32'h73);

`ifdef BUF_TIMEOUT_EN
    // T6: core 3 never arrives; release 16 edges after the first capture
    set_a(0, 3'd3, 3'd3);
    buf_flag = 4'b0111;
    for (int k = 0; k <= 16; k++) begin
      tick();
      chk("t6_rel", 32'(all_buf_flags), 32'(k == 16));
    end
    chk("t6_tmask", 32'(timeout_mask), 32'h8);
    tick();
    chk("t6_s3_v1", s1(0), 0);
    chk("t6_s3_v2", s2(0), 0);
    buf_flag = '0;
    tick();
    chk("t6_rnd", 32'(round_cnt), 2);
    chk("t6_tmask_sticky", 32'(timeout_mask), 32'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
